// File: rtl/cp0_tlb_seq_pkg.sv
// Shared CPU definitions for the CP0 TLB-maintenance sequencer: op codes, FSM states, TLB size.
package cp0_tlb_seq_pkg;

  localparam int unsigned TLB_ENTRIES = 16;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    TLBP  = 3'd1,
    TLBR  = 3'd2,
    TLBWI = 3'd3,
    TLBWR = 3'd4
  } tlb_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StProbe,
    StPwb,
    StRead,
    StRwb,
    StWrite,
    StRefetch
  } tlbseq_state_t;

endpackage

// File: rtl/cp0_tlb_seq_random.sv
// CP0 Random register: free-running down-counter that wraps to the top entry at Wired or 0.
module cp0_random_reg #(
  parameter int unsigned TLB_ENTRIES = cp0_tlb_seq_pkg::TLB_ENTRIES,
  parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TopIdx = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] random_q, random_d;

  // A Wired value at the top entry pins Random there, since the wrap target equals the wrap point.
  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (wired_we) begin
      random_d = TopIdx;
    end else if ((random_q == wired) || (random_q == '0)) begin
      random_d = TopIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= TopIdx;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;

endmodule

// File: rtl/cp0_tlb_seq.sv
// MEM-stage sequencer for TLBP/TLBR/TLBWI/TLBWR: stalls the pipe, drives the TLB ports,
// strobes CP0 write-back and redirects fetch after any op that may change translations.
module cp0_tlb_seq #(
  parameter int unsigned TLB_ENTRIES = cp0_tlb_seq_pkg::TLB_ENTRIES,
  parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  cp0_tlb_seq_pkg::tlb_op_t  mem_op,
  input  logic                      mem_valid,
  input  logic [31:0]               mem_pc,
  input  logic                      wb_flush,
  input  logic [IDX_W-1:0]          cp0_index,
  input  logic [IDX_W-1:0]          cp0_wired,
  input  logic                      cp0_wired_we,
  input  logic                      tlb_s_found,
  input  logic [IDX_W-1:0]          tlb_s_index,
  output logic                      tlb_s_req,
  output logic [IDX_W-1:0]          tlb_r_idx,
  output logic                      tlb_we,
  output logic [IDX_W-1:0]          tlb_w_idx,
  output logic                      cp0_index_we,
  output logic [31:0]               cp0_index_wdata,
  output logic                      cp0_tlbr_we,
  output logic [IDX_W-1:0]          cp0_random,
  output logic                      stall,
  output logic                      refetch,
  output logic [31:0]               refetch_pc
);

  import cp0_tlb_seq_pkg::*;

  tlbseq_state_t    state_q, state_d;
  tlb_op_t          op_q;
  logic [31:0]      pc_q;
  logic             found_q;
  logic [IDX_W-1:0] sidx_q;
  logic [IDX_W-1:0] ridx_q;
  logic             accept;

  // Once accepted the op is the oldest in flight, so wb_flush only matters in the accept cycle.
  assign accept = !rst && (state_q == StIdle) && mem_valid && (mem_op != NONE) && !wb_flush;

  cp0_random_reg #(
    .TLB_ENTRIES (TLB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_random (
    .clk      (clk),
    .rst      (rst),
    .wired    (cp0_wired),
    .wired_we (cp0_wired_we),
    .random   (cp0_random)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= NONE;
      pc_q    <= '0;
      found_q <= 1'b0;
      sidx_q  <= '0;
      ridx_q  <= '0;
    end else begin
      if (accept) begin
        op_q <= mem_op;
        pc_q <= mem_pc;
      end
      if (state_q == StProbe) begin
        found_q <= tlb_s_found;
        sidx_q  <= tlb_s_index;
      end
      if (state_q == StRead) begin
        ridx_q <= cp0_index;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (mem_op)
            TLBP:         state_d = StProbe;
            TLBR:         state_d = StRead;
            TLBWI, TLBWR: state_d = StWrite;
            default:      state_d = StIdle;
          endcase
        end
      end
      StProbe:   state_d = StPwb;
      StPwb:     state_d = StIdle;
      StRead:    state_d = StRwb;
      StRwb:     state_d = StRefetch;
      StWrite:   state_d = StRefetch;
      StRefetch: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Everything is gated by rst so an op caught mid-flight by reset emits no strobe.
  always_comb begin
    tlb_s_req       = 1'b0;
    tlb_r_idx       = ridx_q;
    tlb_we          = 1'b0;
    tlb_w_idx       = '0;
    cp0_index_we    = 1'b0;
    cp0_index_wdata = '0;
    cp0_tlbr_we     = 1'b0;
    stall           = 1'b0;
    refetch         = 1'b0;
    refetch_pc      = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: stall = accept;
        StProbe: begin
          stall     = 1'b1;
          tlb_s_req = 1'b1;
        end
        StPwb: begin
          stall           = 1'b1;
          cp0_index_we    = 1'b1;
          cp0_index_wdata = found_q ? 32'(sidx_q) : 32'h8000_0000;
        end
        StRead: begin
          stall     = 1'b1;
          tlb_r_idx = cp0_index;
        end
        StRwb: begin
          stall       = 1'b1;
          cp0_tlbr_we = 1'b1;
        end
        StWrite: begin
          stall     = 1'b1;
          tlb_we    = 1'b1;
          tlb_w_idx = (op_q == TLBWR) ? cp0_random : cp0_index;
        end
        StRefetch: begin
          refetch    = 1'b1;
          refetch_pc = pc_q + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_tlb_seq.sv
// Directed bench for cp0_tlb_seq: per-cycle compare against an op-age timing model plus
// hand-computed literal expectations.
module tb_cp0_tlb_seq;
  import cp0_tlb_seq_pkg::*;

  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  tlb_op_t       mem_op;
  logic          mem_valid;
  logic [31:0]   mem_pc;
  logic          wb_flush;
  logic [IW-1:0] cp0_index;
  logic [IW-1:0] cp0_wired;
  logic          cp0_wired_we;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic          tlb_s_req;
  logic [IW-1:0] tlb_r_idx;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_idx;
  logic          cp0_index_we;
  logic [31:0]   cp0_index_wdata;
  logic          cp0_tlbr_we;
  logic [IW-1:0] cp0_random;
  logic          stall;
  logic          refetch;
  logic [31:0]   refetch_pc;

  int checks = 0;
  int failures = 0;

  cp0_tlb_seq #(
    .TLB_ENTRIES (16),
    .IDX_W       (IW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_op          (mem_op),
    .mem_valid       (mem_valid),
    .mem_pc          (mem_pc),
    .wb_flush        (wb_flush),
    .cp0_index       (cp0_index),
    .cp0_wired       (cp0_wired),
    .cp0_wired_we    (cp0_wired_we),
    .tlb_s_found     (tlb_s_found),
    .tlb_s_index     (tlb_s_index),
    .tlb_s_req       (tlb_s_req),
    .tlb_r_idx       (tlb_r_idx),
    .tlb_we          (tlb_we),
    .tlb_w_idx       (tlb_w_idx),
    .cp0_index_we    (cp0_index_we),
    .cp0_index_wdata (cp0_index_wdata),
    .cp0_tlbr_we     (cp0_tlbr_we),
    .cp0_random      (cp0_random),
    .stall           (stall),
    .refetch         (refetch),
    .refetch_pc      (refetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tiny TLB stand-in: entry i holds VPN2 0x10000 + 3*i.
  logic [18:0]   eh_vpn;
  logic          hit_any;
  logic [IW-1:0] hit_idx;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (eh_vpn == 19'h1_0000 + 19'(3 * i)) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign tlb_s_found = tlb_s_req & hit_any;
  assign tlb_s_index = hit_idx;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model state: the op in flight and how many cycles have passed since it was accepted.
  logic          m_busy = 1'b0;
  tlb_op_t       m_op = NONE;
  int            m_age = 0;
  logic [31:0]   m_pc = '0;
  logic          m_found = 1'b0;
  logic [IW-1:0] m_sidx = '0;
  logic [IW-1:0] m_ridx = '0;
  int            m_rand = 15;

  logic          e_stall, e_req, e_we, e_iwe, e_rwe, e_ref, e_rchk;
  logic [IW-1:0] e_widx, e_ridx;
  logic [31:0]   e_wdata, e_pc;

  always @(negedge clk) begin
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_iwe = 1'b0; e_rwe = 1'b0; e_ref = 1'b0;
    e_rchk = 1'b0; e_widx = '0; e_ridx = '0; e_wdata = '0; e_pc = '0;
    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (mem_valid && mem_op != NONE && !wb_flush) begin
        e_stall = 1'b1;
        m_busy  = 1'b1;
        m_op    = mem_op;
        m_pc    = mem_pc;
        m_age   = 1;
      end
    end else begin
      case (m_op)
        TLBP: begin
          e_stall = 1'b1;
          if (m_age == 1) begin
            e_req   = 1'b1;
            m_found = hit_any;
            m_sidx  = hit_idx;
          end else begin
            e_iwe   = 1'b1;
            e_wdata = m_found ? {28'd0, m_sidx} : 32'h8000_0000;
            m_busy  = 1'b0;
          end
        end
        TLBR: begin
          if (m_age == 1) begin
            e_stall = 1'b1; e_rchk = 1'b1; e_ridx = cp0_index; m_ridx = cp0_index;
          end else if (m_age == 2) begin
            e_stall = 1'b1; e_rchk = 1'b1; e_ridx = m_ridx; e_rwe = 1'b1;
          end else begin
            e_ref = 1'b1; e_pc = m_pc + 32'd4; m_busy = 1'b0;
          end
        end
        default: begin
          if (m_age == 1) begin
            e_stall = 1'b1; e_we = 1'b1;
            e_widx  = (m_op == TLBWR) ? IW'(m_rand) : cp0_index;
          end else begin
            e_ref = 1'b1; e_pc = m_pc + 32'd4; m_busy = 1'b0;
          end
        end
      endcase
      m_age++;
    end

    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("refetch", {31'd0, refetch}, {31'd0, e_ref});
    chk("tlb_s_req", {31'd0, tlb_s_req}, {31'd0, e_req});
    chk("tlb_we", {31'd0, tlb_we}, {31'd0, e_we});
    chk("cp0_index_we", {31'd0, cp0_index_we}, {31'd0, e_iwe});
    chk("cp0_tlbr_we", {31'd0, cp0_tlbr_we}, {31'd0, e_rwe});
    if (e_we) chk("tlb_w_idx", 32'(tlb_w_idx), 32'(e_widx));
    if (e_iwe) chk("cp0_index_wdata", cp0_index_wdata, e_wdata);
    if (e_rchk) chk("tlb_r_idx", 32'(tlb_r_idx), 32'(e_ridx));
    if (e_ref) chk("refetch_pc", refetch_pc, e_pc);
    if (!rst) chk("cp0_random", 32'(cp0_random), 32'(m_rand));

    if (rst || cp0_wired_we || m_rand == int'(cp0_wired) || m_rand == 0) m_rand = 15;
    else m_rand = m_rand - 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_op = NONE; mem_pc = '0; wb_flush = 1'b0;
    cp0_index = '0; cp0_wired = 4'd4; cp0_wired_we = 1'b0; eh_vpn = '0;
    step(); step();
    look();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_refetch_pc", refetch_pc, 32'd0);
    chk("rst_index_wdata", cp0_index_wdata, 32'd0);
    step(); rst = 1'b0;
    look();
    chk("rand_after_rst", 32'(cp0_random), 32'd15);

    // TLBWR ten cycles after reset with Wired=4.
    repeat (9) step();
    mem_valid = 1'b1; mem_op = TLBWR; mem_pc = 32'h0040_1000;
    look(); chk("tlbwr_accept_stall", {31'd0, stall}, 32'd1);
    step(); mem_valid = 1'b0; mem_op = NONE;
    look(); chk("tlbwr_we", {31'd0, tlb_we}, 32'd1); chk("tlbwr_widx", 32'(tlb_w_idx), 32'd5);
    step();
    look(); chk("tlbwr_refetch", {31'd0, refetch}, 32'd1);
    chk("tlbwr_refetch_pc", refetch_pc, 32'h0040_1004);
    chk("rand_at_wired", 32'(cp0_random), 32'd4);
    step();
    look(); chk("rand_wrap", 32'(cp0_random), 32'd15);

    // TLBP hit on entry 5.
    step(); eh_vpn = 19'h1_0000 + 19'd15; mem_valid = 1'b1; mem_op = TLBP; mem_pc = 32'h100;
    look(); chk("tlbp_accept_stall", {31'd0, stall}, 32'd1);
    step();
    look(); chk("tlbp_s_req", {31'd0, tlb_s_req}, 32'd1);
    step();
    look(); chk("tlbp_hit_we", {31'd0, cp0_index_we}, 32'd1);
    chk("tlbp_hit_wdata", cp0_index_wdata, 32'h0000_0005);
    step(); mem_valid = 1'b0; mem_op = NONE;
    look(); chk("tlbp_done_stall", {31'd0, stall}, 32'd0);

    // TLBP miss.
    step(); eh_vpn = 19'h7_FFFF; mem_valid = 1'b1; mem_op = TLBP;
    step(); step();
    look(); chk("tlbp_miss_wdata", cp0_index_wdata, 32'h8000_0000);
    step(); mem_valid = 1'b0; mem_op = NONE;

    // TLBR index 9 with pc wrap, then a TLBWI held through REFETCH.
    step(); cp0_index = 4'd9; mem_valid = 1'b1; mem_op = TLBR; mem_pc = 32'hFFFF_FFFC;
    step();
    look(); chk("tlbr_r_idx", 32'(tlb_r_idx), 32'd9);
    step(); cp0_index = 4'd3;
    look(); chk("tlbr_we", {31'd0, cp0_tlbr_we}, 32'd1); chk("tlbr_r_idx_held", 32'(tlb_r_idx), 32'd9);
    step(); mem_op = TLBWI; cp0_index = 4'd6; mem_pc = 32'h8000_0100;
    look(); chk("tlbr_refetch_pc", refetch_pc, 32'd0); chk("refetch_no_accept", {31'd0, stall}, 32'd0);
    step();
    look(); chk("b2b_accept", {31'd0, stall}, 32'd1);
    step(); mem_valid = 1'b0; mem_op = NONE;
    look(); chk("tlbwi_widx", 32'(tlb_w_idx), 32'd6);
    step();
    look(); chk("tlbwi_refetch_pc", refetch_pc, 32'h8000_0104);

    // wb_flush in the accept cycle blocks the op.
    step(); mem_valid = 1'b1; mem_op = TLBWI; wb_flush = 1'b1;
    look(); chk("flush_no_stall", {31'd0, stall}, 32'd0);
    step(); mem_valid = 1'b0; mem_op = NONE; wb_flush = 1'b0;
    look(); chk("flush_no_we", {31'd0, tlb_we}, 32'd0);

    // wb_flush during WRITE is ignored.
    step(); mem_valid = 1'b1; mem_op = TLBWI; cp0_index = 4'd7;
    step(); mem_valid = 1'b0; mem_op = NONE; wb_flush = 1'b1;
    look(); chk("flush_write_we", {31'd0, tlb_we}, 32'd1); chk("flush_write_widx", 32'(tlb_w_idx), 32'd7);
    step(); wb_flush = 1'b0;
    look(); chk("flush_write_refetch", {31'd0, refetch}, 32'd1);

    // Reset during READ.
    step(); mem_valid = 1'b1; mem_op = TLBR;
    step(); rst = 1'b1;
    look(); chk("rst_read_stall", {31'd0, stall}, 32'd0);
    step(); rst = 1'b0; mem_valid = 1'b0; mem_op = NONE;
    look(); chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_tlbr_we", {31'd0, cp0_tlbr_we}, 32'd0);
    chk("post_rst_rand", 32'(cp0_random), 32'd15);

    // MTC0 Wired during a TLBWR.
    repeat (3) step();
    mem_valid = 1'b1; mem_op = TLBWR;
    step(); mem_valid = 1'b0; mem_op = NONE; cp0_wired_we = 1'b1;
    look(); chk("wired_we_widx", 32'(tlb_w_idx), 32'd11);
    step(); cp0_wired_we = 1'b0;
    look(); chk("wired_we_rand", 32'(cp0_random), 32'd15);

    // Wired at the top entry pins Random.
    cp0_wired = 4'd15;
    repeat (5) step();
    look(); chk("wired_top_rand", 32'(cp0_random), 32'd15);
    cp0_wired = 4'd0;
    repeat (20) step();

    look();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
